// File: rtl/calc_seq.sv
// calc_seq: buffers matrix-job descriptors, launches each on mem_ctrl with a one-cycle calc_init,
// tracks mem_ctrl back to IDLE and returns a tagged status. Define CALC_SEQ_TIMEOUT_EN for the per-phase watchdog.
module calc_seq #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [31:0]      cmd_base_sp,
  input  logic [31:0]      cmd_base_hash,
  input  logic [31:0]      cmd_base_b,
  input  logic [10:0]      cmd_matrix_size,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             calc_init,
  output logic [2:0]       mem_mode,
  output logic [31:0]      BASE_ADDR_SP,
  output logic [31:0]      BASE_ADDR_HASH,
  output logic [31:0]      BASE_ADDR_B,
  output logic [10:0]      MATRIX_SIZE,
  input  logic [3:0]       ctrl_state,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [TAG_W-1:0] done_tag,
  output logic [1:0]       done_status,
  output logic             busy,
  output logic [15:0]      jobs_done
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = 3 + 3 * 32 + 11 + TAG_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_WAIT_DONE,
    S_REPORT
  } state_t;

  state_t             r_state;
  logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               r_calc_init;
  logic [2:0]         r_mem_mode;
  logic [31:0]        r_base_sp;
  logic [31:0]        r_base_hash;
  logic [31:0]        r_base_b;
  logic [10:0]        r_matrix_size;
  logic               r_done_valid;
  logic [TAG_W-1:0]   r_done_tag;
  logic [1:0]         r_done_status;
  logic [15:0]        r_jobs_done;

  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_legal;
  logic [2:0]         w_h_mode;
  logic [31:0]        w_h_sp;
  logic [31:0]        w_h_hash;
  logic [31:0]        w_h_b;
  logic [10:0]        w_h_size;
  logic [TAG_W-1:0]   w_h_tag;

`ifdef CALC_SEQ_TIMEOUT_EN
  logic [31:0]        r_wdog;
  logic               w_wdog_hit;
  assign w_wdog_hit = (r_wdog == (32'(TIMEOUT_CYCLES) - 32'd1));
`else
  logic               w_unused_timeout;
  assign w_unused_timeout = ^(32'(TIMEOUT_CYCLES));
`endif

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push  = cmd_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && (r_count != '0) && !r_done_valid;
  assign {w_h_mode, w_h_sp, w_h_hash, w_h_b, w_h_size, w_h_tag} = r_mem[r_rd_ptr];
  assign w_legal = ((w_h_mode == 3'd1) || (w_h_mode == 3'd2)) && (w_h_size != 11'd0);

  // Command storage; contents need no reset since pointers/count gate every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_mode, cmd_base_sp, cmd_base_hash, cmd_base_b, cmd_matrix_size, cmd_tag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Job FSM; job fields change only on a legal pop so they stay stable for mem_ctrl's whole job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_calc_init   <= 1'b0;
      r_mem_mode    <= '0;
      r_base_sp     <= '0;
      r_base_hash   <= '0;
      r_base_b      <= '0;
      r_matrix_size <= '0;
      r_done_valid  <= 1'b0;
      r_done_tag    <= '0;
      r_done_status <= '0;
      r_jobs_done   <= '0;
`ifdef CALC_SEQ_TIMEOUT_EN
      r_wdog        <= '0;
`endif
    end else begin
      r_calc_init <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_done_tag <= w_h_tag;
            if (w_legal) begin
              r_mem_mode    <= w_h_mode;
              r_base_sp     <= w_h_sp;
              r_base_hash   <= w_h_hash;
              r_base_b      <= w_h_b;
              r_matrix_size <= w_h_size;
              r_calc_init   <= 1'b1;
              r_state       <= S_LAUNCH;
            end else begin
              r_done_status <= 2'd1;
              r_done_valid  <= 1'b1;
              r_state       <= S_REPORT;
            end
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT_START;
`ifdef CALC_SEQ_TIMEOUT_EN
          r_wdog  <= '0;
`endif
        end
        S_WAIT_START: begin
          if (ctrl_state != 4'd0) begin
            r_state <= S_WAIT_DONE;
`ifdef CALC_SEQ_TIMEOUT_EN
            r_wdog  <= '0;
          end else if (w_wdog_hit) begin
            r_done_status <= 2'd2;
            r_done_valid  <= 1'b1;
            r_state       <= S_REPORT;
          end else begin
            r_wdog <= r_wdog + 32'd1;
`endif
          end
        end
        S_WAIT_DONE: begin
          if (ctrl_state == 4'd0) begin
            r_done_status <= 2'd0;
            r_done_valid  <= 1'b1;
            r_jobs_done   <= r_jobs_done + 16'd1;
            r_state       <= S_REPORT;
`ifdef CALC_SEQ_TIMEOUT_EN
          end else if (w_wdog_hit) begin
            r_done_status <= 2'd2;
            r_done_valid  <= 1'b1;
            r_state       <= S_REPORT;
          end else begin
            r_wdog <= r_wdog + 32'd1;
`endif
          end
        end
        S_REPORT: begin
          if (done_ready) begin
            r_done_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready      = !w_full;
  assign busy           = (r_state != S_IDLE) || (r_count != '0);
  assign calc_init      = r_calc_init;
  assign mem_mode       = r_mem_mode;
  assign BASE_ADDR_SP   = r_base_sp;
  assign BASE_ADDR_HASH = r_base_hash;
  assign BASE_ADDR_B    = r_base_b;
  assign MATRIX_SIZE    = r_matrix_size;
  assign done_valid     = r_done_valid;
  assign done_tag       = r_done_tag;
  assign done_status    = r_done_status;
  assign jobs_done      = r_jobs_done;

endmodule
